// File: rtl/des_debounce.sv
// rtl/des_debounce.sv - Input synchroniser and debouncer for a raw, bouncing level input.
module des_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic busy
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
    logic                   r_out;
    logic                   w_out_nxt;

    // Plain flop chain: no logic between stages so metastability can settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_STABLE;
            r_cnt   <= 8'd0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        case (r_state)
            ST_STABLE: begin
                if (w_sync != r_out) begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_COUNT: begin
                // Any return to the current level throws away the partial count.
                if (w_sync == r_out) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = 8'd0;
                    w_out_nxt   = w_sync;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign out  = r_out;
    assign busy = (r_state == ST_COUNT);

endmodule

// File: tb/tb_des_debounce.sv
// tb/tb_des_debounce.sv - Directed self-checking bench for des_debounce (2 sync stages, 4 debounce cycles).
module tb_des_debounce;

    logic clk;
    logic rst;
    logic r_in;
    logic w_out;
    logic w_busy;

    int n_total;
    int n_pass;

    des_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .in  (r_in),
        .out (w_out),
        .busy(w_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_total = n_total + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Bit e-1 of each mask is: in driven before edge e, out/busy expected just after edge e.
    task automatic run_vec(input string tag, input int n, input logic [15:0] in_mask,
                           input logic [15:0] out_mask, input logic [15:0] busy_mask);
        for (int e = 1; e <= n; e++) begin
            r_in = in_mask[e-1];
            @(posedge clk);
            #2;
            check($sformatf("%s_out_e%0d", tag, e), w_out, out_mask[e-1]);
            check($sformatf("%s_busy_e%0d", tag, e), w_busy, busy_mask[e-1]);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b0;
        r_in    = 1'b0;

        #1;
        check("reset_out_t1", w_out, 1'b0);
        check("reset_busy_t1", w_busy, 1'b0);
        #17;
        check("reset_out_t18", w_out, 1'b0);
        check("reset_busy_t18", w_busy, 1'b0);
        rst = 1'b1;

        run_vec("idle", 3, 16'h0000, 16'h0000, 16'h0000);
        run_vec("rise", 9, 16'h01FF, 16'h01E0, 16'h001C);
        run_vec("fall", 9, 16'h0000, 16'h001F, 16'h001C);
        run_vec("glitch3", 10, 16'h0007, 16'h0000, 16'h001C);
        run_vec("glitch4", 12, 16'h000F, 16'h01E0, 16'h01DC);
        run_vec("bounce", 14, 16'h3FD5, 16'h3800, 16'h0754);
        run_vec("fall2", 9, 16'h0000, 16'h001F, 16'h001C);

        run_vec("pre_rst", 4, 16'h000F, 16'h0000, 16'h000C);
        rst = 1'b0;
        #1;
        check("midrst_out", w_out, 1'b0);
        check("midrst_busy", w_busy, 1'b0);
        @(posedge clk);
        #2;
        check("inrst_out", w_out, 1'b0);
        check("inrst_busy", w_busy, 1'b0);
        rst = 1'b1;
        run_vec("post_rst", 8, 16'h00FF, 16'h00E0, 16'h001C);

        rst = 1'b0;
        #1;
        check("async_clr_out", w_out, 1'b0);
        check("async_clr_busy", w_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/des_debounce.md
DES_DEBOUNCE -- requirements
Module: des_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on in (legal 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive synchronised samples required to accept a new level (legal 2..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 SHALL have port in  input  1  raw, asynchronous, possibly bouncing level.
REQ-006 SHALL have port out  output  1  synchronised, debounced level that drives the downstream edge detector.
REQ-007 SHALL have port busy  output  1  high while a candidate level change is being qualified.

Function
REQ-008 SHALL pass in through a chain of SYNC_STAGES flops; sync = last stage; no logic between stages.
REQ-009 SHALL use an 8-bit counter cnt and a two-state FSM: STABLE, COUNT.
REQ-010 STABLE: if sync == out, SHALL remain in STABLE with cnt=0.
REQ-011 STABLE: if sync != out, SHALL go to COUNT with cnt=1.
REQ-012 COUNT: if sync == out, SHALL return to STABLE with cnt=0 and out unchanged (glitch rejected).
REQ-013 COUNT: if sync != out and cnt == DEBOUNCE_CYCLES-1, SHALL load out <= sync, go to STABLE, cnt=0.
REQ-014 COUNT: otherwise SHALL increment cnt by 1; cnt never exceeds DEBOUNCE_CYCLES-1, never wraps.
REQ-015 busy SHALL be registered-state decode: 1 exactly when FSM is in COUNT.
REQ-016 Latency: a clean level change on in, held, SHALL appear on out at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after the change (first edge that samples the new level = edge 1).
REQ-017 A level on in held for exactly DEBOUNCE_CYCLES sampling edges SHALL be accepted; one held DEBOUNCE_CYCLES-1 edges SHALL be rejected.
REQ-018 Rising and falling changes SHALL be treated symmetrically, with identical latency.
REQ-019 out SHALL change at most once per qualification and only on a clk rising edge, never glitch.
REQ-020 Bouncing that toggles sync during COUNT SHALL restart qualification from STABLE; no partial count carries over.

Reset
REQ-021 rst=0 SHALL immediately, without clk, clear all sync flops, cnt=0, FSM=STABLE, out=0, busy=0.
REQ-022 Reset SHALL dominate any simultaneous clock edge or input change.
REQ-023 Reset asserted mid-COUNT SHALL discard the qualification; after release a change requires full SYNC_STAGES+DEBOUNCE_CYCLES latency.
REQ-024 After rst deasserts, normal operation SHALL begin on the first following rising clk edge; if in=1 at release, out rises after the REQ-016 latency.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, clk period 10 ns)
REQ-025 Reset: rst=0, in=0 for 18 ns -> out=0, busy=0 throughout, including before the first clk edge.
REQ-026 Clean rise: after reset, in 0->1 held -> busy=1 after edges 3,4,5; out=1 and busy=0 after edge 6; then stable.
REQ-027 Glitch: in=1 for 3 sampling edges then 0 -> busy pulses high, out stays 0; in=1 for exactly 4 edges -> out pulses 1, returns to 0 after a further 6 edges.
REQ-028 Bounce: in toggles every 10 ns for 60 ns then settles at 1 -> out unchanged during bounce, out=1 exactly 6 edges after final settle.
REQ-029 Reset mid-count: in 0->1, assert rst after edge 4 -> out=0, busy=0 immediately; release with in=1 -> out=1 at 6th edge after release.
REQ-030 Clean fall: out=1, in 1->0 held -> out=0 at edge 6, busy high edges 3-5.
